// File: rtl/multu_seq_if.sv
// Handshake and operand/result bundle between the EX-stage control path and multu_seq.
interface multu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, dataA, dataB,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, dataA, dataB,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/multu_seq.sv
// Sequential unsigned WIDTHxWIDTH shift-add multiplier; one iteration per clock,
// product lands in HI/LO on the completion edge and done pulses for one cycle.
module multu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic       clk,
  input logic       reset,
  multu_seq_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH:0]     sum;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  // Carry out of the upper-half add becomes the MSB after the right shift.
  always_comb begin
    sum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nxt = {sum, prod[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mcand <= '0;
      prod  <= '0;
      cnt   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            mcand <= bus.dataA;
            prod  <= {{WIDTH{1'b0}}, bus.dataB};
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          prod <= prod_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            hi_r  <= prod_nxt[2*WIDTH-1:WIDTH];
            lo_r  <= prod_nxt[WIDTH-1:0];
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
endmodule
